// File: rtl/serial_or_pkg.sv
// serial_or_pkg: shared FSM state encoding and width limit for serial_or.
package serial_or_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam int SERIAL_OR_MAX_WIDTH = 32;
endpackage

// File: rtl/serial_or_if.sv
// serial_or_if: start/busy/done handshake and operand/result bus; any exists only with SERIAL_OR_ANY_EN.
interface serial_or_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] y;
`ifdef SERIAL_OR_ANY_EN
  logic any;
  modport master(output start, a, b, input busy, done, y, any);
  modport slave(input start, a, b, output busy, done, y, any);
`else
  modport master(output start, a, b, input busy, done, y);
  modport slave(input start, a, b, output busy, done, y);
`endif
endinterface

// File: rtl/nand_or.sv
// nand_or: two-input OR built from three NAND gates.
module nand_or (
  input  logic a,
  input  logic b,
  output logic y
);
  logic na, nb;
  assign na = ~(a & a);
  assign nb = ~(b & b);
  assign y = ~(na & nb);
endmodule

// File: rtl/serial_or.sv
// serial_or: bit-serial a|b through one nand_or, one bit per clock; SERIAL_OR_ANY_EN adds the any flag.
module serial_or
  import serial_or_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_or_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  if (WIDTH < 2 || WIDTH > SERIAL_OR_MAX_WIDTH) begin : g_bad_width
    $error("serial_or: WIDTH out of range");
  end
  state_t state;
  logic [WIDTH-1:0] sa, sb, sy;
  logic [CW-1:0] cnt;
  logic busy, done, bit_y;
  nand_or u_bit_or (.a(sa[0]), .b(sb[0]), .y(bit_y));
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.y = sy;
`ifdef SERIAL_OR_ANY_EN
  logic acc;
  assign bus.any = acc;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sa <= '0;
      sb <= '0;
      sy <= '0;
      cnt <= '0;
`ifdef SERIAL_OR_ANY_EN
      acc <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sa <= bus.a;
          sb <= bus.b;
          sy <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= BUSY;
`ifdef SERIAL_OR_ANY_EN
          acc <= 1'b0;
`endif
        end
        BUSY: begin
          sy <= {bit_y, sy[WIDTH-1:1]};
          sa <= sa >> 1;
          sb <= sb >> 1;
`ifdef SERIAL_OR_ANY_EN
          acc <= acc | bit_y;
`endif
          // exit is tested before incrementing so cnt never wraps
          if (cnt == LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_or.sv
// tb_serial_or: scoreboard bench for serial_or at WIDTH=8 and WIDTH=2.
module tb_serial_or;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_or_if #(.WIDTH(8)) b8 ();
  serial_or_if #(.WIDTH(2)) b2 ();
  serial_or #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  serial_or #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  typedef struct {
    logic [31:0] y;
    logic any;
  } exp_t;
  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] yv);
    exp_t e;
    e.y = yv;
    e.any = |yv;
    sb_q.push_back(e);
  endtask

  task automatic test_reset;
    b8.start = 1'b1;
    b8.a = 8'hFF;
    b8.b = 8'h00;
    rst = 1'b1;
    repeat (3) step;
    tests++; if (b8.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", b8.busy); end
    tests++; if (b8.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", b8.done); end
    tests++; if (b8.y !== 8'h00) begin fails++; $display("FAIL reset_y got %h want 00", b8.y); end
`ifdef SERIAL_OR_ANY_EN
    tests++; if (b8.any !== 1'b0) begin fails++; $display("FAIL reset_any got %b want 0", b8.any); end
`endif
    rst = 1'b0;
    push(32'hFF);
    step;
    b8.start = 1'b0;
    tests++; if (b8.busy !== 1'b1) begin fails++; $display("FAIL start_after_reset busy got %b want 1", b8.busy); end
    begin
      int n;
      exp_t e;
      n = 0;
      while (b8.done !== 1'b1 && n < 20) begin step; n++; end
      e = sb_q.pop_front();
      tests++; if (b8.done !== 1'b1) begin fails++; $display("FAIL reset_op_timeout done never seen"); end
      tests++; if (b8.y !== e.y[7:0]) begin fails++; $display("FAIL reset_op_y got %h want %h", b8.y, e.y[7:0]); end
    end
    step;
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv);
    int n, nb;
    exp_t e;
    b8.a = av;
    b8.b = bv;
    b8.start = 1'b1;
    push({24'd0, av | bv});
    step;
    b8.start = 1'b0;
    b8.a = 8'hXX;
    b8.b = 8'hXX;
    n = 0;
    nb = 0;
    while (b8.done !== 1'b1 && n < 20) begin
      if (b8.busy === 1'b1) nb++;
      step;
      n++;
    end
    e = sb_q.pop_front();
    tests++; if (n !== 8) begin fails++; $display("FAIL latency %h|%h got %0d want 8", av, bv, n); end
    tests++; if (nb !== 8) begin fails++; $display("FAIL busy_cycles %h|%h got %0d want 8", av, bv, nb); end
    tests++; if (b8.busy !== 1'b0) begin fails++; $display("FAIL busy_at_done got %b want 0", b8.busy); end
    tests++; if (b8.y !== e.y[7:0]) begin fails++; $display("FAIL y %h|%h got %h want %h", av, bv, b8.y, e.y[7:0]); end
`ifdef SERIAL_OR_ANY_EN
    tests++; if (b8.any !== e.any) begin fails++; $display("FAIL any %h|%h got %b want %b", av, bv, b8.any, e.any); end
`endif
    step;
    tests++; if (b8.done !== 1'b0) begin fails++; $display("FAIL done_pulse got %b want 0", b8.done); end
    tests++; if (b8.y !== e.y[7:0]) begin fails++; $display("FAIL y_held got %h want %h", b8.y, e.y[7:0]); end
  endtask

  task automatic test_basic;
    run8(8'hA5, 8'h0F);
    run8(8'h00, 8'h00);
    run8(8'h80, 8'h01);
  endtask

  task automatic test_ignore;
    int dones;
    exp_t e;
    b8.a = 8'h0F;
    b8.b = 8'h00;
    b8.start = 1'b1;
    push(32'h0F);
    step;
    b8.start = 1'b0;
    dones = 0;
    for (int n = 0; n < 25; n++) begin
      b8.start = (n == 2);
      b8.a = (n == 2) ? 8'hFF : 8'h00;
      if (b8.done === 1'b1) begin
        dones++;
        e = sb_q.pop_front();
        tests++; if (b8.y !== e.y[7:0]) begin fails++; $display("FAIL ignore_y got %h want %h", b8.y, e.y[7:0]); end
      end
      step;
    end
    b8.start = 1'b0;
    tests++; if (dones !== 1) begin fails++; $display("FAIL ignore_dones got %0d want 1", dones); end
    tests++; if (b8.busy !== 1'b0) begin fails++; $display("FAIL ignore_idle busy got %b want 0", b8.busy); end
  endtask

  task automatic test_abort;
    int dones;
    b8.a = 8'hF0;
    b8.b = 8'h0F;
    b8.start = 1'b1;
    step;
    b8.start = 1'b0;
    repeat (3) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    tests++; if (b8.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", b8.busy); end
    tests++; if (b8.done !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", b8.done); end
    tests++; if (b8.y !== 8'h00) begin fails++; $display("FAIL abort_y got %h want 00", b8.y); end
`ifdef SERIAL_OR_ANY_EN
    tests++; if (b8.any !== 1'b0) begin fails++; $display("FAIL abort_any got %b want 0", b8.any); end
`endif
    dones = 0;
    repeat (15) begin
      if (b8.done === 1'b1) dones++;
      step;
    end
    tests++; if (dones !== 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", dones); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pa[4];
    logic [7:0] pb[4];
    int last, n;
    exp_t e;
    pa = '{8'hF0, 8'h33, 8'hF0, 8'h33};
    pb = '{8'h0F, 8'h44, 8'h0F, 8'h44};
    b8.a = pa[0];
    b8.b = pb[0];
    b8.start = 1'b1;
    push({24'd0, pa[0] | pb[0]});
    last = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      step;
      while (b8.done !== 1'b1 && n < 30) begin step; n++; end
      e = sb_q.pop_front();
      tests++; if (b8.y !== e.y[7:0]) begin fails++; $display("FAIL b2b_y[%0d] got %h want %h", i, b8.y, e.y[7:0]); end
      if (i > 0) begin
        tests++; if (cyc - last !== 10) begin fails++; $display("FAIL b2b_period[%0d] got %0d want 10", i, cyc - last); end
      end
      last = cyc;
      if (i < 3) begin
        b8.a = pa[i+1];
        b8.b = pb[i+1];
        push({24'd0, pa[i+1] | pb[i+1]});
      end else begin
        b8.start = 1'b0;
      end
    end
    repeat (3) step;
    tests++; if (b8.busy !== 1'b0) begin fails++; $display("FAIL b2b_stop busy got %b want 0", b8.busy); end
  endtask

  task automatic test_width2;
    int n;
    exp_t e;
    b2.a = 2'b10;
    b2.b = 2'b01;
    b2.start = 1'b1;
    push(32'h3);
    step;
    b2.start = 1'b0;
    n = 0;
    while (b2.done !== 1'b1 && n < 10) begin step; n++; end
    e = sb_q.pop_front();
    tests++; if (n !== 2) begin fails++; $display("FAIL w2_latency got %0d want 2", n); end
    tests++; if (b2.y !== e.y[1:0]) begin fails++; $display("FAIL w2_y got %b want %b", b2.y, e.y[1:0]); end
`ifdef SERIAL_OR_ANY_EN
    tests++; if (b2.any !== e.any) begin fails++; $display("FAIL w2_any got %b want %b", b2.any, e.any); end
`endif
    step;
    tests++; if (b2.done !== 1'b0) begin fails++; $display("FAIL w2_done_pulse got %b want 0", b2.done); end
  endtask

  initial begin
    b8.start = 1'b0;
    b8.a = '0;
    b8.b = '0;
    b2.start = 1'b0;
    b2.a = '0;
    b2.b = '0;
    test_reset;
    test_basic;
    test_ignore;
    test_abort;
    test_back_to_back;
    test_width2;
    tests++; if (sb_q.size() !== 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
